mii_frame_generator: RTL and testbench
======================================

# mii_frame_generator

Parametrised successor to the fixed 64-bit MII traffic generator: it emits complete, correctly delimited frames instead of a free-running pattern. Width is a parameter, with one control bit per byte lane. Payload length, inter-packet gap, payload mode and frame count are all programmable. It sits on the TX side of the 1.6T MII test path and drives o_tx_data/o_tx_ctrl directly into the MII/PCS under test or a loopback checker.

## Interface
- DATA_WIDTH, 64: bus width in bits; multiple of 8, at least 32.
- CTRL_WIDTH, DATA_WIDTH/8: one control bit per byte lane; must equal DATA_WIDTH/8.
- clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_enable  in  1  run request; level sensitive.
- i_mode  in  2  payload mode: 0 incrementing, 1 constant i_pattern, 2 PRBS7, 3 frame index.
- i_pattern  in  8  constant payload byte for mode 1.
- i_payload_len  in  16  payload bytes per frame; 0 is treated as 1.
- i_ipg_words  in  8  full idle words inserted after the word holding the terminate byte.
- i_frame_count  in  16  frames per run; 0 means continuous.
- o_tx_data  out  DATA_WIDTH  MII data; lane 0 = bits [7:0], sent first.
- o_tx_ctrl  out  CTRL_WIDTH  per-lane control flag; bit i covers lane i.
- o_busy  out  1  high while a frame or its gap is being emitted.
- o_done  out  1  high once i_frame_count frames have been sent; held until i_enable is low.
- o_frames_sent  out  32  frames completed since reset; wraps.

## Operation
- Frame byte stream, with F = 9 + L bytes:
  - 0xFB start, ctrl=1
  - six bytes 0x55, ctrl=0
  - 0xD5 SFD, ctrl=0
  - L payload bytes, ctrl=0
  - 0xFD terminate, ctrl=1
- Every byte past the terminate byte in the same word is idle: 0x07, ctrl=1.
- Each cycle outputs stream bytes k*N .. k*N+N-1, where N = CTRL_WIDTH and k is the word index within the frame.
- Start is always in lane 0, so a frame begins on a word boundary.
- States:
  - IDLE: all lanes idle. Go to FRAME when i_enable=1 and o_done=0.
  - FRAME: emit frame words. After the word containing the terminate byte, go to IPG, or straight to IDLE/FRAME if i_ipg_words=0.
  - IPG: emit i_ipg_words all-idle words, then go to FRAME if enabled and count not reached, otherwise IDLE.
  - DONE condition: the frame count is reached with i_frame_count≠0. o_done is set and the FSM stays in IDLE until i_enable falls; that clears o_done and the run counter.
- i_mode, i_pattern, i_payload_len and i_ipg_words are latched on the cycle the FSM leaves IDLE/IPG for FRAME. Changes during a frame do not affect it.
- Payload modes (byte j = payload index from 0):
  - Mode 0: j mod 256.
  - Mode 1: i_pattern.
  - Mode 3: low 8 bits of o_frames_sent.
  - Mode 2: PRBS7, x^7+x^6+1, seed 0x7F at each frame start, 8 bits per byte, first bit into bit 0.
- i_enable falling mid-frame: the current frame and its IPG complete, then IDLE. Frames are never truncated.
- o_frames_sent and the run counter increment on the cycle the terminate word is output.

## Timing
- Reset (async assert, sync-safe release) sets:
  - o_tx_data: every lane 0x07; o_tx_ctrl: all ones
  - o_busy=0, o_done=0, o_frames_sent=0; FSM in IDLE
- Outputs are registered. The start word appears on the cycle after the edge that samples i_enable=1 in IDLE.
- o_busy is high from the start word through the last IPG word.
- Frames back-to-back with i_ipg_words=0: the next start word directly follows the terminate word.
- Byte offset counter is at least 17 bits, so L=65535 does not overflow.
- Reset asserted mid-frame: outputs go to idle immediately. No terminate byte is emitted.

## Test plan
- DATA_WIDTH=64, mode 0, L=8, ipg 0, count 1 -> three words, then IDLE with o_done=1 and o_frames_sent=1:
  - D5555555555555FB / 01
  - 0706050403020100 / 00
  - 07070707070707FD / FF
- L=1, mode 1, i_pattern=0xA5 -> second word 070707070707FDA5, ctrl FE.
- DATA_WIDTH=32, L=4, mode 0 -> words:
  - 555555FB/1, D5555555/0, 03020100/0, 070707FD/F
- count 3, ipg 2, L=8 -> exactly 3 frames, each terminate word followed by 2 all-idle words. o_done rises with the third terminate word and clears after i_enable drops.
- Drop i_enable one cycle after the start word, count 0 -> the frame completes fully, then idle forever with o_frames_sent=1.
- Assert i_rst_n low mid-payload -> the same cycle shows all 0x07/ctrl all ones with o_busy=0. After release with i_enable=1, a fresh start word is emitted with a reset payload counter (mode 0 byte 0 = 0x00).

Source files
------------

// File: rtl/mii_frame_generator.sv
// MII TX frame generator: emits start/preamble/SFD/payload/terminate frames
// with a programmable inter-packet gap, payload mode and frame count.
//
// state   | meaning
// S_IDLE  | all-idle words; starts a frame when enabled and the run is not done
// S_FRAME | emitting frame words; offs_q is the stream byte index of the next word
// S_IPG   | emitting full idle words after a terminate word
module mii_frame_generator #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [1:0]            i_mode,
  input  logic [7:0]            i_pattern,
  input  logic [15:0]           i_payload_len,
  input  logic [7:0]            i_ipg_words,
  input  logic [15:0]           i_frame_count,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [31:0]           o_frames_sent
);

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_IPG} state_t;

  localparam int NB = CTRL_WIDTH;
  localparam int OW = 20;
  localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {CTRL_WIDTH{8'h07}};

  state_t          state;
  logic [OW-1:0]   offs_q;
  logic [16:0]     len_q;
  logic [1:0]      mode_q;
  logic [7:0]      pat_q;
  logic [7:0]      ipg_q;
  logic [7:0]      ipg_cnt;
  logic [6:0]      prbs_q;
  logic [31:0]     run_q;

  logic            go;
  logic            fresh;
  logic [16:0]     eff_len;
  logic [1:0]      eff_mode;
  logic [7:0]      eff_pat;
  logic [7:0]      eff_ipg;
  logic [OW-1:0]   base;
  logic [OW-1:0]   term_pos;
  logic [OW-1:0]   pos;
  logic [6:0]      prbs_s;
  logic            fb;
  logic [7:0]      lane_byte;
  logic            lane_ctrl;
  logic [DATA_WIDTH-1:0] word_data;
  logic [CTRL_WIDTH-1:0] word_ctrl;
  logic            has_term;
  logic [31:0]     run_next;
  logic            reached;
  logic            cont;

  // A word with offs_q == 0 in S_FRAME is a start word of a back-to-back or
  // post-gap frame, so it takes live settings exactly like a start from S_IDLE.
  always_comb begin
    go        = (state == S_IDLE) && i_enable && !o_done;
    fresh     = go || ((state == S_FRAME) && (offs_q == '0));
    eff_len   = fresh ? ((i_payload_len == 16'd0) ? 17'd1 : {1'b0, i_payload_len}) : len_q;
    eff_mode  = fresh ? i_mode : mode_q;
    eff_pat   = fresh ? i_pattern : pat_q;
    eff_ipg   = fresh ? i_ipg_words : ipg_q;
    base      = fresh ? '0 : offs_q;
    term_pos  = OW'(eff_len) + OW'(8);
    prbs_s    = fresh ? 7'h7F : prbs_q;
    pos       = '0;
    fb        = 1'b0;
    lane_byte = 8'h07;
    lane_ctrl = 1'b1;
    word_data = IDLE_WORD;
    word_ctrl = '1;
    for (int i = 0; i < NB; i++) begin
      pos       = base + OW'(i);
      lane_byte = 8'h07;
      lane_ctrl = 1'b1;
      if (pos == '0) begin
        lane_byte = 8'hFB;
      end else if (pos < OW'(7)) begin
        lane_byte = 8'h55;
        lane_ctrl = 1'b0;
      end else if (pos == OW'(7)) begin
        lane_byte = 8'hD5;
        lane_ctrl = 1'b0;
      end else if (pos < term_pos) begin
        lane_ctrl = 1'b0;
        case (eff_mode)
          2'd0: lane_byte = pos[7:0] - 8'd8;
          2'd1: lane_byte = eff_pat;
          2'd2: begin
            for (int b = 0; b < 8; b++) begin
              fb           = prbs_s[6] ^ prbs_s[5];
              lane_byte[b] = fb;
              prbs_s       = {prbs_s[5:0], fb};
            end
          end
          default: lane_byte = o_frames_sent[7:0];
        endcase
      end else if (pos == term_pos) begin
        lane_byte = 8'hFD;
      end
      word_data[8*i +: 8] = lane_byte;
      word_ctrl[i]        = lane_ctrl;
    end
    has_term = (base + OW'(NB)) > term_pos;
    run_next = run_q + 32'd1;
    reached  = (i_frame_count != 16'd0) && (run_next >= {16'd0, i_frame_count});
    cont     = i_enable && !reached;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      offs_q        <= '0;
      len_q         <= 17'd1;
      mode_q        <= 2'd0;
      pat_q         <= 8'd0;
      ipg_q         <= 8'd0;
      ipg_cnt       <= 8'd0;
      prbs_q        <= 7'h7F;
      run_q         <= 32'd0;
      o_tx_data     <= IDLE_WORD;
      o_tx_ctrl     <= '1;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_frames_sent <= 32'd0;
    end else begin
      case (state)
        S_IDLE, S_FRAME: begin
          if (go || (state == S_FRAME)) begin
            o_tx_data <= word_data;
            o_tx_ctrl <= word_ctrl;
            o_busy    <= 1'b1;
            if (fresh) begin
              len_q  <= eff_len;
              mode_q <= eff_mode;
              pat_q  <= eff_pat;
              ipg_q  <= eff_ipg;
            end
            if (has_term) begin
              o_frames_sent <= o_frames_sent + 32'd1;
              run_q         <= run_next;
              offs_q        <= '0;
              if (reached) o_done <= 1'b1;
              if (eff_ipg != 8'd0) begin
                state   <= S_IPG;
                ipg_cnt <= eff_ipg;
              end else if (cont) begin
                state <= S_FRAME;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              state  <= S_FRAME;
              offs_q <= base + OW'(NB);
              prbs_q <= prbs_s;
            end
          end else begin
            o_tx_data <= IDLE_WORD;
            o_tx_ctrl <= '1;
            o_busy    <= 1'b0;
            // Dropping enable while idle ends the run and re-arms the counter.
            if (!i_enable) begin
              o_done <= 1'b0;
              run_q  <= 32'd0;
            end
          end
        end
        S_IPG: begin
          o_tx_data <= IDLE_WORD;
          o_tx_ctrl <= '1;
          o_busy    <= 1'b1;
          ipg_cnt   <= ipg_cnt - 8'd1;
          if (ipg_cnt == 8'd1) begin
            state <= (i_enable && !o_done) ? S_FRAME : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mii_frame_generator.sv
// Bench for mii_frame_generator: directed vector table, hand corner sequences
// and randomized runs against a byte-stream reference model.
module tb_mii_frame_generator;

  localparam logic [63:0] IW = 64'h0707070707070707;
  localparam logic [63:0] SW = 64'hD5555555555555FB;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [7:0]  pat;
  logic [15:0] len;
  logic [7:0]  ipg;
  logic [15:0] cnt;
  logic [63:0] data64;
  logic [7:0]  ctrl64;
  logic        busy64;
  logic        done64;
  logic [31:0] fs64;

  logic        en32;
  logic [31:0] data32;
  logic [3:0]  ctrl32;
  logic        busy32;
  logic        done32;
  logic [31:0] fs32;

  int checks;
  int failures;

  mii_frame_generator #(.DATA_WIDTH(64)) u_dut64 (
    .clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_mode(mode), .i_pattern(pat),
    .i_payload_len(len), .i_ipg_words(ipg), .i_frame_count(cnt),
    .o_tx_data(data64), .o_tx_ctrl(ctrl64), .o_busy(busy64), .o_done(done64),
    .o_frames_sent(fs64)
  );

  mii_frame_generator #(.DATA_WIDTH(32)) u_dut32 (
    .clk(clk), .i_rst_n(rst_n), .i_enable(en32), .i_mode(2'd0), .i_pattern(8'd0),
    .i_payload_len(16'd4), .i_ipg_words(8'd0), .i_frame_count(16'd1),
    .o_tx_data(data32), .o_tx_ctrl(ctrl32), .o_busy(busy32), .o_done(done32),
    .o_frames_sent(fs32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  pat;
    logic [15:0] len;
    logic [7:0]  ipg;
    logic [15:0] cnt;
    logic [63:0] data;
    logic [7:0]  ctrl;
    logic        busy;
    logic        done;
    logic [31:0] fs;
  } vec_t;

  vec_t vt[21];

  // Reference stream: bytes and control flags of every expected word in order.
  logic [7:0] eb[$];
  logic       ec[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic e, logic [1:0] m, logic [7:0] p, logic [15:0] l,
                              logic [7:0] g, logic [15:0] c, logic [63:0] d,
                              logic [7:0] ct, logic b, logic dn, logic [31:0] f);
    vec_t v;
    v.en = e; v.mode = m; v.pat = p; v.len = l; v.ipg = g; v.cnt = c;
    v.data = d; v.ctrl = ct; v.busy = b; v.done = dn; v.fs = f;
    return v;
  endfunction

  function automatic void push_b(logic [7:0] b, logic c);
    eb.push_back(b);
    ec.push_back(c);
  endfunction

  function automatic void push_frame(int l, int m, logic [7:0] p, logic [7:0] fidx, int g);
    logic       sq[$];
    logic [7:0] b;
    int         ll;
    ll = (l == 0) ? 1 : l;
    b  = 8'h00;
    push_b(8'hFB, 1'b1);
    for (int i = 0; i < 6; i++) push_b(8'h55, 1'b0);
    push_b(8'hD5, 1'b0);
    // PRBS7 bit sequence: b[n] = b[n-7] ^ b[n-6], seeded with seven ones.
    for (int i = 0; i < 7; i++) sq.push_back(1'b1);
    for (int j = 0; j < ll; j++) begin
      case (m)
        0: b = 8'(j);
        1: b = p;
        2: begin
          for (int k = 0; k < 8; k++) begin
            b[k] = sq[sq.size()-7] ^ sq[sq.size()-6];
            sq.push_back(b[k]);
          end
        end
        default: b = fidx;
      endcase
      push_b(b, 1'b0);
    end
    push_b(8'hFD, 1'b1);
    while (eb.size() % 8 != 0) push_b(8'h07, 1'b1);
    for (int i = 0; i < g * 8; i++) push_b(8'h07, 1'b1);
  endfunction

  logic [31:0] exp_fs;
  logic [63:0] ed;
  logic [7:0]  ecl;
  int          rl, rm, rg, rc;
  logic [7:0]  rp;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; en = 1'b0; en32 = 1'b0;
    mode = 2'd0; pat = 8'd0; len = 16'd8; ipg = 8'd0; cnt = 16'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("reset data", data64, IW);
    chk("reset status", {22'd0, ctrl64, busy64, done64, fs64}, {22'd0, 8'hFF, 1'b0, 1'b0, 32'd0});

    // 32-bit bus, L=4, mode 0, one frame
    en32 = 1'b1;
    tick(); chk("dw32 w0", {28'd0, ctrl32, data32}, {28'd0, 4'h1, 32'h555555FB});
    tick(); chk("dw32 w1", {28'd0, ctrl32, data32}, {28'd0, 4'h0, 32'hD5555555});
    tick(); chk("dw32 w2", {28'd0, ctrl32, data32}, {28'd0, 4'h0, 32'h03020100});
    tick(); chk("dw32 w3", {28'd0, ctrl32, data32}, {28'd0, 4'hF, 32'h070707FD});
    chk("dw32 done", {30'd0, busy32, done32, fs32}, {30'd0, 1'b1, 1'b1, 32'd1});
    en32 = 1'b0;
    tick(); chk("dw32 clear", {28'd0, ctrl32, data32}, {28'd0, 4'hF, 32'h07070707});
    chk("dw32 clear st", {62'd0, busy32, done32}, 64'd0);

    vt[0]  = mk(1, 0, 8'h00, 8, 0, 1, SW, 8'h01, 1, 0, 0);
    vt[1]  = mk(1, 0, 8'h00, 8, 0, 1, 64'h0706050403020100, 8'h00, 1, 0, 0);
    vt[2]  = mk(1, 0, 8'h00, 8, 0, 1, 64'h07070707070707FD, 8'hFF, 1, 1, 1);
    vt[3]  = mk(1, 0, 8'h00, 8, 0, 1, IW, 8'hFF, 0, 1, 1);
    vt[4]  = mk(0, 0, 8'h00, 8, 0, 1, IW, 8'hFF, 0, 0, 1);
    vt[5]  = mk(1, 1, 8'hA5, 1, 0, 1, SW, 8'h01, 1, 0, 1);
    vt[6]  = mk(1, 1, 8'hA5, 1, 0, 1, 64'h070707070707FDA5, 8'hFE, 1, 1, 2);
    vt[7]  = mk(0, 1, 8'hA5, 1, 0, 1, IW, 8'hFF, 0, 0, 2);
    vt[8]  = mk(1, 0, 8'h00, 0, 2, 2, SW, 8'h01, 1, 0, 2);
    vt[9]  = mk(1, 0, 8'h00, 0, 2, 2, 64'h070707070707FD00, 8'hFE, 1, 0, 3);
    vt[10] = mk(1, 0, 8'h00, 0, 2, 2, IW, 8'hFF, 1, 0, 3);
    vt[11] = mk(1, 0, 8'h00, 0, 2, 2, IW, 8'hFF, 1, 0, 3);
    vt[12] = mk(1, 0, 8'h00, 0, 2, 2, SW, 8'h01, 1, 0, 3);
    vt[13] = mk(1, 0, 8'h00, 0, 2, 2, 64'h070707070707FD00, 8'hFE, 1, 1, 4);
    vt[14] = mk(1, 0, 8'h00, 0, 2, 2, IW, 8'hFF, 1, 1, 4);
    vt[15] = mk(1, 0, 8'h00, 0, 2, 2, IW, 8'hFF, 1, 1, 4);
    vt[16] = mk(1, 0, 8'h00, 0, 2, 2, IW, 8'hFF, 0, 1, 4);
    vt[17] = mk(0, 0, 8'h00, 0, 2, 2, IW, 8'hFF, 0, 0, 4);
    vt[18] = mk(1, 3, 8'h00, 2, 0, 1, SW, 8'h01, 1, 0, 4);
    vt[19] = mk(1, 3, 8'h00, 2, 0, 1, 64'h0707070707FD0404, 8'hFC, 1, 1, 5);
    vt[20] = mk(0, 3, 8'h00, 2, 0, 1, IW, 8'hFF, 0, 0, 5);

    for (int i = 0; i < 21; i++) begin
      en = vt[i].en; mode = vt[i].mode; pat = vt[i].pat;
      len = vt[i].len; ipg = vt[i].ipg; cnt = vt[i].cnt;
      tick();
      chk($sformatf("vec%0d data", i), data64, vt[i].data);
      chk($sformatf("vec%0d status", i), {22'd0, ctrl64, busy64, done64, fs64},
          {22'd0, vt[i].ctrl, vt[i].busy, vt[i].done, vt[i].fs});
    end

    // Enable dropped right after the start word in continuous mode
    mode = 2'd0; len = 16'd8; ipg = 8'd0; cnt = 16'd0; en = 1'b1;
    tick(); chk("drop start", data64, SW);
    en = 1'b0;
    tick(); chk("drop payload", data64, 64'h0706050403020100);
    tick(); chk("drop term", data64, 64'h07070707070707FD);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("drop idle%0d", i), {22'd0, ctrl64, busy64, done64, fs64},
          {22'd0, 8'hFF, 1'b0, 1'b0, 32'd6});
      chk($sformatf("drop idle%0d data", i), data64, IW);
    end
    exp_fs = 32'd6;

    // Randomized runs against the stream model
    for (int it = 0; it < 20; it++) begin
      rl = (it % 5 == 4) ? int'($urandom_range(100, 300)) : int'($urandom_range(0, 40));
      rm = int'($urandom_range(0, 3));
      rp = 8'($urandom_range(0, 255));
      rg = int'($urandom_range(0, 3));
      rc = int'($urandom_range(1, 3));
      eb.delete(); ec.delete();
      for (int f = 0; f < rc; f++) push_frame(rl, rm, rp, 8'(exp_fs + 32'(f)), rg);
      mode = 2'(rm); pat = rp; len = 16'(rl); ipg = 8'(rg); cnt = 16'(rc); en = 1'b1;
      for (int w = 0; w < eb.size() / 8; w++) begin
        for (int i = 0; i < 8; i++) begin
          ed[8*i +: 8] = eb[w*8+i];
          ecl[i]       = ec[w*8+i];
        end
        tick();
        chk($sformatf("rnd%0d w%0d data", it, w), data64, ed);
        chk($sformatf("rnd%0d w%0d ctrl", it, w), {55'd0, ctrl64, busy64}, {55'd0, ecl, 1'b1});
      end
      exp_fs = exp_fs + 32'(rc);
      tick();
      chk($sformatf("rnd%0d end", it), {22'd0, ctrl64, busy64, done64, fs64},
          {22'd0, 8'hFF, 1'b0, 1'b1, exp_fs});
      en = 1'b0;
      tick();
      chk($sformatf("rnd%0d clear", it), {62'd0, busy64, done64}, 64'd0);
    end

    // Reset in the middle of the payload, then a fresh frame
    mode = 2'd0; len = 16'd40; ipg = 8'd0; cnt = 16'd0; en = 1'b1;
    tick(); chk("rst start", data64, SW);
    tick(); chk("rst payload", data64, 64'h0706050403020100);
    #3 rst_n = 1'b0;
    #1;
    chk("rst async data", data64, IW);
    chk("rst async status", {22'd0, ctrl64, busy64, done64, fs64},
        {22'd0, 8'hFF, 1'b0, 1'b0, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    tick(); chk("rst restart", data64, SW);
    tick(); chk("rst restart payload", data64, 64'h0706050403020100);
    en = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
